// File: rtl/ysyx_23060236_mxbar_pkg.sv
// Shared types and constants for the multi-master AXI crossbar.
// Holds FSM encodings, AXI response/burst codes and the local-window check.
package ysyx_23060236_mxbar_pkg;

  typedef enum logic [2:0] {RIdle, RAddr, RLocal, RData, RErr} rd_state_e;
  typedef enum logic [2:0] {WIdle, WAddr, WData, WResp, WErr} wr_state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] BurstIncr  = 2'b01;

  // Unsigned wrap-around subtraction makes a single compare cover both bounds.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr - base) < size;
  endfunction

endpackage

// File: rtl/ysyx_23060236_rr_arb.sv
// N-way round-robin arbiter: searches from ptr_i+1 (mod N) for the first requester.
// Purely combinational; the caller owns the pointer register.
module ysyx_23060236_rr_arb #(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= int'(N); k++) begin
      cand = IdxW'((int'(ptr_i) + k) % int'(N));
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060236_mxbar.sv
// N-master round-robin AXI4 crossbar onto one downstream port, with independent
// read/write FSMs and single-beat reads of a local window routed to a local slave.
module ysyx_23060236_mxbar
  import ysyx_23060236_mxbar_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter logic [31:0] LOCAL_BASE = 32'h0200_0000,
  parameter logic [31:0] LOCAL_SIZE = 32'h0001_0000,
  parameter logic [3:0]  ID_BASE    = 4'h0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    m_arvalid,
  output logic [N-1:0]    m_arready,
  input  logic [N*32-1:0] m_araddr,
  input  logic [N*8-1:0]  m_arlen,
  input  logic [N*3-1:0]  m_arsize,
  input  logic [N*2-1:0]  m_arburst,
  output logic [N-1:0]    m_rvalid,
  input  logic [N-1:0]    m_rready,
  output logic [31:0]     m_rdata,
  output logic [1:0]      m_rresp,
  output logic            m_rlast,
  input  logic [N-1:0]    m_awvalid,
  output logic [N-1:0]    m_awready,
  input  logic [N*32-1:0] m_awaddr,
  input  logic [N*8-1:0]  m_awlen,
  input  logic [N*3-1:0]  m_awsize,
  input  logic [N*2-1:0]  m_awburst,
  input  logic [N-1:0]    m_wvalid,
  output logic [N-1:0]    m_wready,
  input  logic [N*32-1:0] m_wdata,
  input  logic [N*4-1:0]  m_wstrb,
  output logic [N-1:0]    m_bvalid,
  input  logic [N-1:0]    m_bready,
  output logic [1:0]      m_bresp,
  input  logic            io_master_awready,
  output logic            io_master_awvalid,
  output logic [31:0]     io_master_awaddr,
  output logic [3:0]      io_master_awid,
  output logic [7:0]      io_master_awlen,
  output logic [2:0]      io_master_awsize,
  output logic [1:0]      io_master_awburst,
  input  logic            io_master_wready,
  output logic            io_master_wvalid,
  output logic [31:0]     io_master_wdata,
  output logic [3:0]      io_master_wstrb,
  output logic            io_master_wlast,
  output logic            io_master_bready,
  input  logic            io_master_bvalid,
  input  logic [1:0]      io_master_bresp,
  input  logic [3:0]      io_master_bid,
  input  logic            io_master_arready,
  output logic            io_master_arvalid,
  output logic [31:0]     io_master_araddr,
  output logic [3:0]      io_master_arid,
  output logic [7:0]      io_master_arlen,
  output logic [2:0]      io_master_arsize,
  output logic [1:0]      io_master_arburst,
  output logic            io_master_rready,
  input  logic            io_master_rvalid,
  input  logic [1:0]      io_master_rresp,
  input  logic [31:0]     io_master_rdata,
  input  logic            io_master_rlast,
  input  logic [3:0]      io_master_rid,
  output logic [31:0]     local_araddr,
  output logic            local_arvalid,
  input  logic            local_arready,
  input  logic [31:0]     local_rdata,
  input  logic [1:0]      local_rresp,
  input  logic            local_rvalid,
  output logic            local_rready
);

  localparam int unsigned IdxW = $clog2(N);

  // Routing uses the registered grant, so downstream IDs are never looked at.
  logic unused_ids;
  assign unused_ids = ^{io_master_rid, io_master_bid};

  logic [31:0] araddr_a [N];
  logic [7:0]  arlen_a  [N];
  logic [2:0]  arsize_a [N];
  logic [1:0]  arburst_a[N];
  logic [31:0] awaddr_a [N];
  logic [7:0]  awlen_a  [N];
  logic [2:0]  awsize_a [N];
  logic [1:0]  awburst_a[N];
  logic [31:0] wdata_a  [N];
  logic [3:0]  wstrb_a  [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign araddr_a[i]  = m_araddr[32*i +: 32];
    assign arlen_a[i]   = m_arlen[8*i +: 8];
    assign arsize_a[i]  = m_arsize[3*i +: 3];
    assign arburst_a[i] = m_arburst[2*i +: 2];
    assign awaddr_a[i]  = m_awaddr[32*i +: 32];
    assign awlen_a[i]   = m_awlen[8*i +: 8];
    assign awsize_a[i]  = m_awsize[3*i +: 3];
    assign awburst_a[i] = m_awburst[2*i +: 2];
    assign wdata_a[i]   = m_wdata[32*i +: 32];
    assign wstrb_a[i]   = m_wstrb[4*i +: 4];
  end

  rd_state_e       rd_state_q, rd_state_d;
  logic [IdxW-1:0] rptr_q, rptr_d, rg_q, rg_d;
  logic [31:0]     raddr_q, raddr_d;
  logic [7:0]      rlen_q, rlen_d;
  logic [2:0]      rsize_q, rsize_d;
  logic [1:0]      rburst_q, rburst_d;
  logic            lar_done_q, lar_done_d;

  wr_state_e       wr_state_q, wr_state_d;
  logic [IdxW-1:0] wptr_q, wptr_d, wg_q, wg_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [7:0]      wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]      wsize_q, wsize_d;
  logic [1:0]      wburst_q, wburst_d;
  logic            werr_b_q, werr_b_d;

  logic [N-1:0]    ar_gnt, aw_gnt;
  logic [IdxW-1:0] ar_idx, aw_idx;
  logic            ar_valid, aw_valid;

  ysyx_23060236_rr_arb #(.N(N)) u_ar_arb (
    .req_i  (m_arvalid),
    .ptr_i  (rptr_q),
    .gnt_o  (ar_gnt),
    .idx_o  (ar_idx),
    .valid_o(ar_valid)
  );

  ysyx_23060236_rr_arb #(.N(N)) u_aw_arb (
    .req_i  (m_awvalid),
    .ptr_i  (wptr_q),
    .gnt_o  (aw_gnt),
    .idx_o  (aw_idx),
    .valid_o(aw_valid)
  );

  always_comb begin
    rd_state_d        = rd_state_q;
    rptr_d            = rptr_q;
    rg_d              = rg_q;
    raddr_d           = raddr_q;
    rlen_d            = rlen_q;
    rsize_d           = rsize_q;
    rburst_d          = rburst_q;
    lar_done_d        = lar_done_q;
    m_arready         = '0;
    m_rvalid          = '0;
    m_rdata           = '0;
    m_rresp           = RespOkay;
    m_rlast           = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_araddr  = raddr_q;
    io_master_arid    = ID_BASE + 4'(rg_q);
    io_master_arlen   = rlen_q;
    io_master_arsize  = rsize_q;
    io_master_arburst = rburst_q;
    io_master_rready  = 1'b0;
    local_arvalid     = 1'b0;
    local_araddr      = raddr_q;
    local_rready      = 1'b0;
    case (rd_state_q)
      RIdle: begin
        // Gated by reset so no grant is offered while the block is held in reset.
        if (ar_valid && !reset) begin
          m_arready  = ar_gnt;
          rg_d       = ar_idx;
          raddr_d    = araddr_a[ar_idx];
          rlen_d     = arlen_a[ar_idx];
          rsize_d    = arsize_a[ar_idx];
          rburst_d   = arburst_a[ar_idx];
          lar_done_d = 1'b0;
          if (in_window(araddr_a[ar_idx], LOCAL_BASE, LOCAL_SIZE)) begin
            rd_state_d = (arlen_a[ar_idx] != 8'd0) ? RErr : RLocal;
          end else begin
            rd_state_d = RAddr;
          end
        end
      end
      RAddr: begin
        io_master_arvalid = 1'b1;
        if (io_master_arready) rd_state_d = RData;
      end
      RData: begin
        m_rvalid[rg_q]   = io_master_rvalid;
        m_rdata          = io_master_rdata;
        m_rresp          = io_master_rresp;
        m_rlast          = io_master_rlast;
        io_master_rready = m_rready[rg_q];
        if (io_master_rvalid && m_rready[rg_q] && io_master_rlast) begin
          rptr_d     = rg_q;
          rd_state_d = RIdle;
        end
      end
      RLocal: begin
        if (!lar_done_q) begin
          local_arvalid = 1'b1;
          if (local_arready) lar_done_d = 1'b1;
        end else begin
          m_rvalid[rg_q] = local_rvalid;
          m_rdata        = local_rdata;
          m_rresp        = local_rresp;
          m_rlast        = 1'b1;
          local_rready   = m_rready[rg_q];
          if (local_rvalid && m_rready[rg_q]) begin
            rptr_d     = rg_q;
            rd_state_d = RIdle;
          end
        end
      end
      RErr: begin
        m_rvalid[rg_q] = 1'b1;
        m_rresp        = RespSlverr;
        m_rlast        = 1'b1;
        if (m_rready[rg_q]) rd_state_d = RIdle;
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_comb begin
    wr_state_d        = wr_state_q;
    wptr_d            = wptr_q;
    wg_d              = wg_q;
    waddr_d           = waddr_q;
    wlen_d            = wlen_q;
    wsize_d           = wsize_q;
    wburst_d          = wburst_q;
    wcnt_d            = wcnt_q;
    werr_b_d          = werr_b_q;
    m_awready         = '0;
    m_wready          = '0;
    m_bvalid          = '0;
    m_bresp           = RespOkay;
    io_master_awvalid = 1'b0;
    io_master_awaddr  = waddr_q;
    io_master_awid    = ID_BASE + 4'(wg_q);
    io_master_awlen   = wlen_q;
    io_master_awsize  = wsize_q;
    io_master_awburst = wburst_q;
    io_master_wvalid  = 1'b0;
    io_master_wdata   = '0;
    io_master_wstrb   = '0;
    io_master_wlast   = 1'b0;
    io_master_bready  = 1'b0;
    case (wr_state_q)
      WIdle: begin
        if (aw_valid && !reset) begin
          m_awready  = aw_gnt;
          wg_d       = aw_idx;
          waddr_d    = awaddr_a[aw_idx];
          wlen_d     = awlen_a[aw_idx];
          wsize_d    = awsize_a[aw_idx];
          wburst_d   = awburst_a[aw_idx];
          wcnt_d     = 8'd0;
          werr_b_d   = 1'b0;
          wr_state_d = in_window(awaddr_a[aw_idx], LOCAL_BASE, LOCAL_SIZE) ? WErr : WAddr;
        end
      end
      WAddr: begin
        io_master_awvalid = 1'b1;
        if (io_master_awready) wr_state_d = WData;
      end
      WData: begin
        // wlast comes from our own beat count; the upstream master's framing is not trusted.
        io_master_wvalid = m_wvalid[wg_q];
        io_master_wdata  = wdata_a[wg_q];
        io_master_wstrb  = wstrb_a[wg_q];
        io_master_wlast  = (wcnt_q == wlen_q);
        m_wready[wg_q]   = io_master_wready;
        if (m_wvalid[wg_q] && io_master_wready) begin
          if (wcnt_q == wlen_q) wr_state_d = WResp;
          else wcnt_d = wcnt_q + 8'd1;
        end
      end
      WResp: begin
        m_bvalid[wg_q]   = io_master_bvalid;
        m_bresp          = io_master_bresp;
        io_master_bready = m_bready[wg_q];
        if (io_master_bvalid && m_bready[wg_q]) begin
          wptr_d     = wg_q;
          wr_state_d = WIdle;
        end
      end
      WErr: begin
        // Drain the whole burst locally before answering with SLVERR.
        if (!werr_b_q) begin
          m_wready[wg_q] = 1'b1;
          if (m_wvalid[wg_q]) begin
            if (wcnt_q == wlen_q) werr_b_d = 1'b1;
            else wcnt_d = wcnt_q + 8'd1;
          end
        end else begin
          m_bvalid[wg_q] = 1'b1;
          m_bresp        = RespSlverr;
          if (m_bready[wg_q]) wr_state_d = WIdle;
        end
      end
      default: wr_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= RIdle;
      rptr_q     <= IdxW'(N - 1);
      rg_q       <= '0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rsize_q    <= '0;
      rburst_q   <= BurstIncr;
      lar_done_q <= 1'b0;
      wr_state_q <= WIdle;
      wptr_q     <= IdxW'(N - 1);
      wg_q       <= '0;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wsize_q    <= '0;
      wburst_q   <= BurstIncr;
      wcnt_q     <= '0;
      werr_b_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rptr_q     <= rptr_d;
      rg_q       <= rg_d;
      raddr_q    <= raddr_d;
      rlen_q     <= rlen_d;
      rsize_q    <= rsize_d;
      rburst_q   <= rburst_d;
      lar_done_q <= lar_done_d;
      wr_state_q <= wr_state_d;
      wptr_q     <= wptr_d;
      wg_q       <= wg_d;
      waddr_q    <= waddr_d;
      wlen_q     <= wlen_d;
      wsize_q    <= wsize_d;
      wburst_q   <= wburst_d;
      wcnt_q     <= wcnt_d;
      werr_b_q   <= werr_b_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_mxbar.sv
// Scoreboard bench for the crossbar: random masters, behavioural downstream and
// local slaves, and a monitor that checks every delivered beat against expectations.
module tb_ysyx_23060236_mxbar;

  localparam int N = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N*32-1:0] m_araddr, m_awaddr, m_wdata;
  logic [N*8-1:0] m_arlen, m_awlen;
  logic [N*3-1:0] m_arsize, m_awsize;
  logic [N*2-1:0] m_arburst, m_awburst;
  logic [31:0] m_rdata;
  logic [1:0] m_rresp, m_bresp;
  logic m_rlast;
  logic [N-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [N*4-1:0] m_wstrb;
  logic io_master_awready, io_master_awvalid, io_master_wready, io_master_wvalid, io_master_wlast;
  logic [31:0] io_master_awaddr, io_master_wdata, io_master_araddr, io_master_rdata;
  logic [3:0] io_master_awid, io_master_wstrb, io_master_bid, io_master_arid, io_master_rid;
  logic [7:0] io_master_awlen, io_master_arlen;
  logic [2:0] io_master_awsize, io_master_arsize;
  logic [1:0] io_master_awburst, io_master_arburst, io_master_bresp, io_master_rresp;
  logic io_master_bready, io_master_bvalid, io_master_arready, io_master_arvalid;
  logic io_master_rready, io_master_rvalid, io_master_rlast;
  logic [31:0] local_araddr, local_rdata;
  logic local_arvalid, local_arready, local_rvalid, local_rready;
  logic [1:0] local_rresp;

  ysyx_23060236_mxbar #(.N(N)) dut (
    .clock(clock), .reset(reset),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_bresp(m_bresp),
    .io_master_awready(io_master_awready), .io_master_awvalid(io_master_awvalid),
    .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst), .io_master_wready(io_master_wready),
    .io_master_wvalid(io_master_wvalid), .io_master_wdata(io_master_wdata),
    .io_master_wstrb(io_master_wstrb), .io_master_wlast(io_master_wlast),
    .io_master_bready(io_master_bready), .io_master_bvalid(io_master_bvalid),
    .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
    .io_master_arready(io_master_arready), .io_master_arvalid(io_master_arvalid),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst), .io_master_rready(io_master_rready),
    .io_master_rvalid(io_master_rvalid), .io_master_rresp(io_master_rresp),
    .io_master_rdata(io_master_rdata), .io_master_rlast(io_master_rlast),
    .io_master_rid(io_master_rid),
    .local_araddr(local_araddr), .local_arvalid(local_arvalid), .local_arready(local_arready),
    .local_rdata(local_rdata), .local_rresp(local_rresp), .local_rvalid(local_rvalid),
    .local_rready(local_rready)
  );

  int checks = 0;
  int errors = 0;

  // Read expectation: [35] compare data, [34] rlast, [33:32] rresp, [31:0] rdata.
  logic [35:0] exp_r [N][$];
  logic [1:0]  exp_b [N][$];
  logic [3:0]  arid_log[$];
  int ds_ar_cnt = 0, ds_aw_cnt = 0, local_ar_cnt = 0, ds_w_cnt = 0;
  int rbeats[N];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic in_win(input logic [31:0] a);
    return (a >= 32'h0200_0000) && (a <= 32'h0200_FFFF);
  endfunction

  function automatic logic [31:0] ds_rdata(input logic [31:0] a, input int b);
    return a ^ (32'h9E37_79B9 * (32'(b) + 32'd1));
  endfunction

  function automatic logic [1:0] ds_bresp(input logic [31:0] a);
    return a[5] ? 2'b10 : 2'b00;
  endfunction

  // ---------------- master agents ----------------
  task automatic do_read(input int i, input logic [31:0] a, input logic [7:0] len);
    int t;
    if (in_win(a)) begin
      if (len != 8'd0) exp_r[i].push_back({1'b0, 1'b1, 2'b10, 32'h0});
      else exp_r[i].push_back({1'b1, 1'b1, 2'b00, ~a});
    end else begin
      for (int b = 0; b <= int'(len); b++)
        exp_r[i].push_back({1'b1, b == int'(len), 2'b00, ds_rdata(a, b)});
    end
    @(posedge clock); #1;
    m_arvalid[i] = 1'b1;
    m_araddr[32*i +: 32] = a;
    m_arlen[8*i +: 8] = len;
    m_arsize[3*i +: 3] = 3'd2;
    m_arburst[2*i +: 2] = 2'b01;
    t = 0;
    do begin @(negedge clock); t++; end while (!m_arready[i] && t < 300);
    chk("ar_grant", m_arready[i], 1'b1);
    @(posedge clock); #1;
    m_arvalid[i] = 1'b0;
    t = 0;
    while (exp_r[i].size() != 0 && t < 600) begin @(negedge clock); t++; end
    chk("r_drained", exp_r[i].size(), 0);
  endtask

  task automatic do_write(input int i, input logic [31:0] a, input logic [7:0] len);
    int t;
    exp_b[i].push_back(in_win(a) ? 2'b10 : ds_bresp(a));
    @(posedge clock); #1;
    m_awvalid[i] = 1'b1;
    m_awaddr[32*i +: 32] = a;
    m_awlen[8*i +: 8] = len;
    m_awsize[3*i +: 3] = 3'd2;
    m_awburst[2*i +: 2] = 2'b01;
    t = 0;
    do begin @(negedge clock); t++; end while (!m_awready[i] && t < 300);
    chk("aw_grant", m_awready[i], 1'b1);
    @(posedge clock); #1;
    m_awvalid[i] = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      m_wvalid[i] = 1'b1;
      m_wdata[32*i +: 32] = a + 32'(b);
      m_wstrb[4*i +: 4] = 4'hF;
      t = 0;
      do begin @(negedge clock); t++; end while (!m_wready[i] && t < 300);
      chk("w_accept", m_wready[i], 1'b1);
      @(posedge clock); #1;
    end
    m_wvalid[i] = 1'b0;
    t = 0;
    while (exp_b[i].size() != 0 && t < 600) begin @(negedge clock); t++; end
    chk("b_drained", exp_b[i].size(), 0);
  endtask

  task automatic rand_read(input int i);
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) do_read(i, 32'h8000_0000 | ($urandom & 32'h00FF_FFFC), 8'($urandom_range(0, 7)));
    else if (r < 9) do_read(i, 32'h0200_0000 | ($urandom & 32'h0000_FFFC), 8'd0);
    else do_read(i, 32'h0200_0000 | ($urandom & 32'h0000_FFFC), 8'($urandom_range(1, 3)));
  endtask

  task automatic rand_write(input int i);
    if ($urandom_range(0, 4) != 0)
      do_write(i, 32'h8000_0000 | ($urandom & 32'h00FF_FFFC), 8'($urandom_range(0, 7)));
    else
      do_write(i, 32'h0200_0000 | ($urandom & 32'h0000_FFFC), 8'($urandom_range(0, 3)));
  endtask

  initial begin
    forever begin
      @(posedge clock); #1;
      m_rready = 2'($urandom);
      m_bready = 2'($urandom);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        for (int i = 0; i < N; i++) begin exp_r[i].delete(); exp_b[i].delete(); end
      end else begin
        if (m_rvalid != '0) chk("r_onehot", $onehot(m_rvalid), 1'b1);
        if (m_bvalid != '0) chk("b_onehot", $onehot(m_bvalid), 1'b1);
        for (int i = 0; i < N; i++) begin
          if (m_rvalid[i] && m_rready[i]) begin
            rbeats[i]++;
            if (exp_r[i].size() == 0) chk("r_unexpected_beat", i, 99);
            else begin
              e = exp_r[i].pop_front();
              chk("r_last", m_rlast, e[34]);
              chk("r_resp", m_rresp, e[33:32]);
              if (e[35]) chk("r_data", m_rdata, e[31:0]);
            end
          end
          if (m_bvalid[i] && m_bready[i]) begin
            if (exp_b[i].size() == 0) chk("b_unexpected", i, 99);
            else chk("b_resp", m_bresp, exp_b[i].pop_front());
          end
        end
      end
    end
  end

  // ---------------- downstream read slave ----------------
  initial begin
    logic have, hs_r;
    logic [31:0] a;
    logic [7:0] len;
    int beat;
    have = 0; a = 0; len = 0; beat = 0;
    forever begin
      @(negedge clock);
      hs_r = 1'b0;
      if (reset) have = 1'b0;
      else if (io_master_arvalid && io_master_arready) begin
        ds_ar_cnt++;
        chk("ds_ar_outside_window", in_win(io_master_araddr), 1'b0);
        chk("ds_arburst", io_master_arburst, 2'b01);
        arid_log.push_back(io_master_arid);
        have = 1'b1; a = io_master_araddr; len = io_master_arlen; beat = 0;
      end else if (io_master_rvalid && io_master_rready) begin
        hs_r = 1'b1;
        if (beat == int'(len)) have = 1'b0;
        else beat++;
      end
      @(posedge clock); #1;
      io_master_arready = !have && ($urandom_range(0, 1) == 1);
      io_master_rvalid  = have && ((io_master_rvalid && !hs_r) || $urandom_range(0, 3) != 0);
      io_master_rdata   = ds_rdata(a, beat);
      io_master_rlast   = (beat == int'(len));
      io_master_rresp   = 2'b00;
      io_master_rid     = 4'hF;
    end
  end

  // ---------------- local slave ----------------
  initial begin
    logic have, hs_r;
    logic [31:0] a;
    have = 0; a = 0;
    forever begin
      @(negedge clock);
      hs_r = 1'b0;
      if (reset) have = 1'b0;
      else if (local_arvalid && local_arready) begin
        local_ar_cnt++;
        chk("local_ar_in_window", in_win(local_araddr), 1'b1);
        have = 1'b1; a = local_araddr;
      end else if (local_rvalid && local_rready) begin
        hs_r = 1'b1; have = 1'b0;
      end
      @(posedge clock); #1;
      local_arready = !have && ($urandom_range(0, 1) == 1);
      local_rvalid  = have && ((local_rvalid && !hs_r) || $urandom_range(0, 1) == 1);
      local_rdata   = ~a;
      local_rresp   = 2'b00;
    end
  end

  // ---------------- downstream write slave ----------------
  initial begin
    logic have, wdone, hs_b;
    logic [31:0] a;
    logic [7:0] len;
    int beat;
    have = 0; wdone = 0; a = 0; len = 0; beat = 0;
    forever begin
      @(negedge clock);
      hs_b = 1'b0;
      if (reset) have = 1'b0;
      else begin
        if (io_master_awvalid && io_master_awready) begin
          ds_aw_cnt++;
          chk("ds_aw_outside_window", in_win(io_master_awaddr), 1'b0);
          have = 1'b1; a = io_master_awaddr; len = io_master_awlen; beat = 0; wdone = 1'b0;
        end
        if (io_master_wvalid && io_master_wready) begin
          ds_w_cnt++;
          chk("ds_wdata", io_master_wdata, a + 32'(beat));
          chk("ds_wlast", io_master_wlast, beat == int'(len));
          chk("ds_wstrb", io_master_wstrb, 4'hF);
          if (beat == int'(len)) wdone = 1'b1;
          else beat++;
        end
        if (io_master_bvalid && io_master_bready) begin
          hs_b = 1'b1; have = 1'b0;
        end
      end
      @(posedge clock); #1;
      io_master_awready = !have && ($urandom_range(0, 1) == 1);
      io_master_wready  = have && !wdone && ($urandom_range(0, 3) != 0);
      io_master_bvalid  = have && wdone && ((io_master_bvalid && !hs_b) || $urandom_range(0, 1) == 1);
      io_master_bresp   = ds_bresp(a);
      io_master_bid     = 4'hF;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n0, c_ds, c_loc, c_aw, c_w, rb, t;
    m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    m_awvalid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
    m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_rready = '0; m_bready = '0;
    io_master_arready = 0; io_master_rvalid = 0; io_master_rdata = 0; io_master_rlast = 0;
    io_master_rresp = 0; io_master_rid = 0; io_master_awready = 0; io_master_wready = 0;
    io_master_bvalid = 0; io_master_bresp = 0; io_master_bid = 0;
    local_arready = 0; local_rvalid = 0; local_rdata = 0; local_rresp = 0;
    for (int i = 0; i < N; i++) rbeats[i] = 0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    m_arvalid = 2'b11;
    m_awvalid = 2'b11;
    @(negedge clock);
    chk("reset_readies", {m_arready, m_awready, m_wready}, 0);
    chk("reset_valids", {m_rvalid, m_bvalid, io_master_arvalid, io_master_awvalid,
                         io_master_wvalid, local_arvalid}, 0);
    @(posedge clock); #1;
    m_arvalid = '0;
    m_awvalid = '0;
    reset = 1'b0;

    // Simultaneous requests: master 0 wins first, then master 1.
    n0 = arid_log.size();
    fork
      do_read(0, 32'h8000_0100, 8'd1);
      do_read(1, 32'h8000_1200, 8'd0);
    join
    chk("first_arid_m0", arid_log.size() >= n0 + 2 ? arid_log[n0] : 4'hE, 4'h0);
    chk("second_arid_m1", arid_log.size() >= n0 + 2 ? arid_log[n0 + 1] : 4'hE, 4'h1);

    rb = rbeats[1];
    do_read(1, 32'h8000_0000, 8'd3);
    chk("m1_burst_beats", rbeats[1] - rb, 4);

    c_ds = ds_ar_cnt; c_loc = local_ar_cnt;
    do_read(0, 32'h0200_BFF8, 8'd0);
    chk("local_no_ds_ar", ds_ar_cnt - c_ds, 0);
    chk("local_one_ar", local_ar_cnt - c_loc, 1);

    c_ds = ds_ar_cnt; c_loc = local_ar_cnt; c_aw = ds_aw_cnt; c_w = ds_w_cnt;
    do_read(0, 32'h0200_0000, 8'd1);
    do_write(0, 32'h0200_0000, 8'd0);
    do_write(1, 32'h0200_FFFC, 8'd2);
    chk("err_no_ds_ar", ds_ar_cnt - c_ds, 0);
    chk("err_no_local_ar", local_ar_cnt - c_loc, 0);
    chk("err_no_ds_aw", ds_aw_cnt - c_aw, 0);
    chk("err_no_ds_w", ds_w_cnt - c_w, 0);

    // Window edges: just below and just above route downstream.
    c_ds = ds_ar_cnt;
    do_read(0, 32'h01FF_FFFC, 8'd0);
    do_read(1, 32'h0201_0000, 8'd0);
    chk("edge_ds_ar", ds_ar_cnt - c_ds, 2);

    c_w = ds_w_cnt;
    fork
      do_write(1, 32'h8000_1040, 8'd3);
      do_read(0, 32'h8000_0200, 8'd3);
    join
    chk("w4_beats", ds_w_cnt - c_w, 4);

    fork
      begin for (int k = 0; k < 25; k++) rand_read(0); end
      begin for (int k = 0; k < 25; k++) rand_read(1); end
      begin for (int k = 0; k < 25; k++) rand_write(0); end
      begin for (int k = 0; k < 25; k++) rand_write(1); end
    join

    // Leave the read pointer at master 0, then abort a master-1 burst with reset.
    do_read(0, 32'h8000_0300, 8'd0);
    for (int b = 0; b < 4; b++) exp_r[1].push_back({1'b1, b == 3, 2'b00, ds_rdata(32'h8000_1300, b)});
    rb = rbeats[1];
    @(posedge clock); #1;
    m_arvalid[1] = 1'b1; m_araddr[63:32] = 32'h8000_1300; m_arlen[15:8] = 8'd3;
    t = 0;
    do begin @(negedge clock); t++; end while (!m_arready[1] && t < 300);
    chk("rst_ar_grant", m_arready[1], 1'b1);
    @(posedge clock); #1;
    m_arvalid[1] = 1'b0;
    t = 0;
    while (rbeats[1] == rb && t < 300) begin @(negedge clock); t++; end
    chk("rst_first_beat", rbeats[1] - rb, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("midburst_reset_valids", {m_rvalid, m_bvalid, io_master_arvalid, io_master_awvalid,
                                  io_master_wvalid, local_arvalid, m_arready}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    n0 = arid_log.size();
    fork
      do_read(0, 32'h8000_0400, 8'd0);
      do_read(1, 32'h8000_1400, 8'd0);
    join
    chk("post_reset_arid_m0", arid_log.size() >= n0 + 2 ? arid_log[n0] : 4'hE, 4'h0);
    chk("post_reset_arid_m1", arid_log.size() >= n0 + 2 ? arid_log[n0 + 1] : 4'hE, 4'h1);

    repeat (5) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
